dcache_tag_write_queue: RTL and testbench
=========================================

# dcache_tag_write_queue

Downstream consumer of the DCache tag-write arbiter. Accepts the arbitrated {way_en, paddr} tag-write stream, which has no back-pressure, buffers it in a small FIFO, and drives a single-ported tag SRAM. The SRAM is shared with the load-pipe tag read. After reset the block also sweeps the array to zero tags. Read-vs-pending-write set collisions are reported so the load pipe can replay.

## Interface
- NWAYS, 8, ways per set (width of way_en)
- NSETS, 128, sets; set index = addr[12:6]
- PADDR_W, 36, physical address width; tag = addr[35:12], TAG_W = 24
- DEPTH, 4, write FIFO entries (power of two)
- STARVE_MAX, 8, consecutive read-blocked cycles before a write is forced
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low
- io_in_valid  in  1  tag-write request; no ready is returned
- io_in_bits_way_en  in  NWAYS  one-hot target way
- io_in_bits_addr  in  PADDR_W  line physical address
- io_rd_valid  in  1  load-pipe tag read request
- io_rd_set  in  7  read set index
- io_rd_nack  out  1  read not serviced this cycle; requester replays
- io_sram_ren  out  1  SRAM read enable
- io_sram_wen  out  1  SRAM write enable
- io_sram_set  out  7  SRAM set (read or write)
- io_sram_way_en  out  NWAYS  write way mask
- io_sram_tag  out  TAG_W(+1)  write data
- io_init_done  out  1  zero-sweep finished
- io_overflow  out  1  sticky; a request was dropped

## Operation
- States: INIT and RUN.
  - INIT: an init counter runs 0..NSETS-1. Each cycle it writes tag 0 to set=counter with way_en all-ones. Reads are nacked. Incoming requests still enqueue.
  - When the counter reaches NSETS-1, the state moves to RUN on the next edge and io_init_done rises.
- Enqueue: when io_in_valid, write {way_en, addr[12:6], addr[35:12]} at the tail.
  - Full and no dequeue this cycle: drop the request and set io_overflow. io_overflow clears only on reset.
  - Full with a dequeue in the same cycle: the enqueue succeeds.
- RUN port arbitration, evaluated each cycle:
  - Forced write: FIFO non-empty and starve counter == STARVE_MAX. The head is written and any read is nacked.
  - Otherwise io_rd_valid with no conflict: read granted (io_sram_ren, io_sram_set = io_rd_set).
  - Otherwise FIFO non-empty: the head is written and dequeued.
- Conflict: io_rd_valid and any valid FIFO entry has set == io_rd_set. The read is nacked, which permits a write that same cycle.
- io_rd_nack = io_rd_valid & ~(read granted).
- Starve counter:
  - Increments while the FIFO is non-empty and no write issues.
  - Resets to 0 on any write or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- io_sram_ren and io_sram_wen are never both high.

## Timing
- Reset values:
  - io_init_done = 0, io_overflow = 0.
  - FIFO empty; init counter = 0; starve counter = 0.
  - INIT state, so io_sram_wen = 1 with set 0 in the first cycle after reset release.
- All SRAM outputs and io_rd_nack are combinational from registered state plus io_rd_*. They are not a function of io_in_*.
- Write latency: a request enqueued at edge t can be written in cycle t+1 at the earliest. There is no enqueue-to-write bypass.
- INIT lasts exactly NSETS cycles.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.
- An asserted reset mid-sweep or mid-drain clears everything and restarts INIT. Buffered writes are lost.

## Configuration
- DCACHE_TAG_PARITY_EN
  - Defined: io_sram_tag is TAG_W+1 bits, with {even parity of tag, tag}. Init writes parity 0.
  - Undefined: io_sram_tag is TAG_W bits and no parity logic exists.

## Structure
- Shared package `dcache_tag_pkg`:
  - Constants: NWAYS, NSETS, TAG_W, IDX_LSB = 6, IDX_MSB = 12.
  - Typedef tag_wr_entry_t {way_en, set, tag}.
  - Function tag_parity().
- One sub-module: `dcache_tag_wr_fifo`, the DEPTH-entry FIFO. It exposes per-entry valid and set for the conflict compare. Arbitration, INIT and the starve logic live in the top.

## Test plan
- Reset release:
  - io_sram_wen = 1 for 128 consecutive cycles, sets 0..127, way_en 0xFF, tag 0.
  - io_init_done rises in cycle 129.
  - A read issued during INIT -> io_rd_nack = 1.
- RUN, idle read port, single write with addr 0x0_1234_5678, way_en 0x04 -> next cycle write with set 0x59, tag 0x012345, way_en 0x04.
- Pending write to set 5 plus io_rd_valid with set 5 -> io_rd_nack = 1 and the write issues that cycle. Next cycle, a read of set 5 is granted.
- Reads to set 9 every cycle with one pending write to set 3 -> 8 reads granted, then a forced write in cycle 9 with the read nacked.
- 5 back-to-back writes while reads hold the port -> 4 buffered, io_overflow = 1 and stays high. A later drain writes exactly 4 entries in order.
- With DCACHE_TAG_PARITY_EN, write tag 0x000007 -> io_sram_tag = 0x1000007.

Source files
------------

// File: rtl/dcache_tag_pkg.sv
// Shared types and constants for the DCache tag-write queue.
// Optional feature macro: DCACHE_TAG_PARITY_EN (adds an even-parity bit to the SRAM tag).
package dcache_tag_pkg;

  localparam int NWAYS      = 8;
  localparam int NSETS      = 128;
  localparam int PADDR_W    = 36;
  localparam int TAG_W      = 24;
  localparam int IDX_LSB    = 6;
  localparam int IDX_MSB    = 12;
  localparam int SET_W      = IDX_MSB - IDX_LSB + 1;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;
  localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

`ifdef DCACHE_TAG_PARITY_EN
  localparam int SRAM_TAG_W = TAG_W + 1;
`else
  localparam int SRAM_TAG_W = TAG_W;
`endif

  typedef struct packed {
    logic [NWAYS-1:0] way_en;
    logic [SET_W-1:0] set;
    logic [TAG_W-1:0] tag;
  } tag_wr_entry_t;

  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic tag_parity(input logic [TAG_W-1:0] tag);
    return ^tag;
  endfunction

endpackage

// File: rtl/dcache_tag_wr_fifo.sv
// DEPTH-entry tag-write FIFO. Exposes per-entry valid/set so the top can
// detect read-vs-pending-write set collisions. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is dropped.
module dcache_tag_wr_fifo
  import dcache_tag_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  tag_wr_entry_t                push_entry,
  input  logic                         pop,
  output tag_wr_entry_t                head,
  output logic                         empty,
  output logic                         drop,
  output logic [DEPTH-1:0]             ent_valid,
  output logic [DEPTH-1:0][SET_W-1:0]  ent_set
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  tag_wr_entry_t    mem_q [DEPTH];
  tag_wr_entry_t    mem_d [DEPTH];
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;
  assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Next-state for pointers, valid bits and storage; pop is applied before
  // push so a full-FIFO push can reuse the slot being freed.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    mem_d    = mem_q;
    if (pop_ok) begin
      vld_d[rd_ptr_q[PTR_W-1:0]] = 1'b0;
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
    if (push_ok) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = push_entry;
      vld_d[wr_ptr_q[PTR_W-1:0]] = 1'b1;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
  end

  // State registers; reset discards any buffered writes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
      mem_q    <= mem_d;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      assign ent_valid[gi] = vld_q[gi];
      assign ent_set[gi]   = mem_q[gi].set;
    end
  endgenerate

endmodule

// File: rtl/dcache_tag_write_queue.sv
// DCache tag-write queue: buffers the arbitrated tag-write stream, zero-sweeps
// the tag SRAM after reset, then shares the single SRAM port between load-pipe
// reads and queued writes with a starvation bound on the writes.
// Optional feature macro: DCACHE_TAG_PARITY_EN.
module dcache_tag_write_queue
  import dcache_tag_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_in_valid,
  input  logic [NWAYS-1:0]      io_in_bits_way_en,
  input  logic [PADDR_W-1:0]    io_in_bits_addr,
  input  logic                  io_rd_valid,
  input  logic [SET_W-1:0]      io_rd_set,
  output logic                  io_rd_nack,
  output logic                  io_sram_ren,
  output logic                  io_sram_wen,
  output logic [SET_W-1:0]      io_sram_set,
  output logic [NWAYS-1:0]      io_sram_way_en,
  output logic [SRAM_TAG_W-1:0] io_sram_tag,
  output logic                  io_init_done,
  output logic                  io_overflow
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [SET_W-1:0]        init_cnt_q, init_cnt_d;
  logic [STARVE_W-1:0]     starve_q, starve_d;
  logic                    overflow_q, overflow_d;

  tag_wr_entry_t           in_entry;
  tag_wr_entry_t           head;
  logic                    fifo_empty;
  logic                    fifo_drop;
  logic                    fifo_pop;
  logic [DEPTH-1:0]        ent_valid;
  logic [DEPTH-1:0][SET_W-1:0] ent_set;
  logic [DEPTH-1:0]        set_hit;
  logic                    conflict;
  logic                    forced;
  logic                    rd_grant;
  logic                    wr_issue;
  logic [TAG_W-1:0]        tag_raw;
  logic                    unused_addr_lsbs;

  // Line offset bits carry no tag or index information.
  assign unused_addr_lsbs = ^io_in_bits_addr[IDX_LSB-1:0];

  assign in_entry.way_en = io_in_bits_way_en;
  assign in_entry.set    = io_in_bits_addr[IDX_MSB:IDX_LSB];
  assign in_entry.tag    = io_in_bits_addr[PADDR_W-1:IDX_MSB];

  dcache_tag_wr_fifo u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (io_in_valid),
    .push_entry (in_entry),
    .pop        (fifo_pop),
    .head       (head),
    .empty      (fifo_empty),
    .drop       (fifo_drop),
    .ent_valid  (ent_valid),
    .ent_set    (ent_set)
  );

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign set_hit[gi] = ent_valid[gi] && (ent_set[gi] == io_rd_set);
    end
  endgenerate

  // A read that would race a pending write to the same set must replay.
  assign conflict = io_rd_valid & (|set_hit);

  // Port arbitration, init sweep, starve counter and sticky overflow.
  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    starve_d       = starve_q;
    overflow_d     = overflow_q | fifo_drop;
    forced         = 1'b0;
    rd_grant       = 1'b0;
    wr_issue       = 1'b0;
    fifo_pop       = 1'b0;
    io_sram_ren    = 1'b0;
    io_sram_wen    = 1'b0;
    io_sram_set    = '0;
    io_sram_way_en = '0;
    tag_raw        = '0;
    case (state_q)
      ST_INIT: begin
        io_sram_wen    = 1'b1;
        io_sram_set    = init_cnt_q;
        io_sram_way_en = '1;
        starve_d       = '0;
        init_cnt_d     = init_cnt_q + SET_W'(1);
        if (init_cnt_q == SET_W'(NSETS - 1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        forced   = ~fifo_empty && (starve_q == STARVE_W'(STARVE_MAX));
        rd_grant = io_rd_valid & ~forced & ~conflict;
        wr_issue = ~fifo_empty & ~rd_grant;
        fifo_pop = wr_issue;
        if (rd_grant) begin
          io_sram_ren = 1'b1;
          io_sram_set = io_rd_set;
        end else if (wr_issue) begin
          io_sram_wen    = 1'b1;
          io_sram_set    = head.set;
          io_sram_way_en = head.way_en;
          tag_raw        = head.tag;
        end
        if (wr_issue || fifo_empty) begin
          starve_d = '0;
        end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
          starve_d = starve_q + STARVE_W'(1);
        end
      end
    endcase
  end

  assign io_rd_nack   = io_rd_valid & ~rd_grant;
  assign io_init_done = (state_q == ST_RUN);
  assign io_overflow  = overflow_q;

`ifdef DCACHE_TAG_PARITY_EN
  assign io_sram_tag = {tag_parity(tag_raw), tag_raw};
`else
  assign io_sram_tag = tag_raw;
`endif

  // Control registers; reset restarts the zero sweep.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      starve_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      starve_q   <= starve_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_dcache_tag_write_queue.sv
// Self-checking bench for dcache_tag_write_queue: directed scenarios plus
// randomized traffic checked against a queue-based behavioural model.
module tb_dcache_tag_write_queue;
  import dcache_tag_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  io_in_valid;
  logic [NWAYS-1:0]      io_in_bits_way_en;
  logic [PADDR_W-1:0]    io_in_bits_addr;
  logic                  io_rd_valid;
  logic [SET_W-1:0]      io_rd_set;
  logic                  io_rd_nack;
  logic                  io_sram_ren;
  logic                  io_sram_wen;
  logic [SET_W-1:0]      io_sram_set;
  logic [NWAYS-1:0]      io_sram_way_en;
  logic [SRAM_TAG_W-1:0] io_sram_tag;
  logic                  io_init_done;
  logic                  io_overflow;

  dcache_tag_write_queue dut (
    .clock             (clock),
    .reset             (reset),
    .io_in_valid       (io_in_valid),
    .io_in_bits_way_en (io_in_bits_way_en),
    .io_in_bits_addr   (io_in_bits_addr),
    .io_rd_valid       (io_rd_valid),
    .io_rd_set         (io_rd_set),
    .io_rd_nack        (io_rd_nack),
    .io_sram_ren       (io_sram_ren),
    .io_sram_wen       (io_sram_wen),
    .io_sram_set       (io_sram_set),
    .io_sram_way_en    (io_sram_way_en),
    .io_sram_tag       (io_sram_tag),
    .io_init_done      (io_init_done),
    .io_overflow       (io_overflow)
  );

  always #5 clock = ~clock;

  // Reference model: cycles since reset release, pending-write queue,
  // starvation count and sticky overflow flag.
  typedef struct {
    logic [7:0]  way;
    logic [6:0]  set;
    logic [23:0] tag;
  } mentry_t;

  mentry_t m_q[$];
  int      m_cycle;
  int      m_starve;
  bit      m_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Last sampled DUT outputs, for the directed scenarios.
  logic                  o_ren, o_wen, o_nack, o_ovf;
  logic [6:0]            o_set;
  logic [7:0]            o_way;
  logic [SRAM_TAG_W-1:0] o_tag;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  function automatic logic [SRAM_TAG_W-1:0] exp_tag(input logic [23:0] t);
`ifdef DCACHE_TAG_PARITY_EN
    return {^t, t};
`else
    return t;
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cycle  = 0;
    m_starve = 0;
    m_ovf    = 1'b0;
  endtask

  // Called at a negedge: asserts reset across one rising edge, checks the
  // reset-state outputs, releases at the next negedge.
  task automatic apply_reset();
    reset = 1'b0;
    io_in_valid = 1'b0; io_in_bits_way_en = '0; io_in_bits_addr = '0;
    io_rd_valid = 1'b0; io_rd_set = '0;
    #1;
    check("rst_init_done", io_init_done, 0);
    check("rst_overflow", io_overflow, 0);
    check("rst_wen", io_sram_wen, 1);
    check("rst_set", io_sram_set, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive at negedge, check outputs against the model,
  // advance the model on the rising edge, return at the next negedge.
  task automatic do_cycle(input bit iv, input logic [7:0] way, input logic [35:0] addr,
                          input bit rv, input logic [6:0] rs);
    bit      in_init, forced, conflict, grant, wr;
    mentry_t e;
    io_in_valid = iv; io_in_bits_way_en = way; io_in_bits_addr = addr;
    io_rd_valid = rv; io_rd_set = rs;
    #1;
    o_ren = io_sram_ren; o_wen = io_sram_wen; o_nack = io_rd_nack; o_ovf = io_overflow;
    o_set = io_sram_set; o_way = io_sram_way_en; o_tag = io_sram_tag;
    in_init = (m_cycle < NSETS);
    wr = 1'b0;
    check("init_done", io_init_done, !in_init);
    check("overflow", o_ovf, m_ovf);
    if (in_init) begin
      check("init_wen", o_wen, 1);
      check("init_ren", o_ren, 0);
      check("init_set", o_set, 64'(m_cycle));
      check("init_way", o_way, 8'hFF);
      check("init_tag", o_tag, 0);
      check("init_nack", o_nack, rv);
    end else begin
      forced = (m_q.size() != 0) && (m_starve == STARVE_MAX);
      conflict = 1'b0;
      foreach (m_q[i]) if (rv && m_q[i].set == rs) conflict = 1'b1;
      grant = rv && !forced && !conflict;
      wr = (m_q.size() != 0) && !grant;
      check("ren", o_ren, grant);
      check("wen", o_wen, wr);
      check("nack", o_nack, rv && !grant);
      if (grant) check("rd_set", o_set, rs);
      if (wr) begin
        check("wr_set", o_set, m_q[0].set);
        check("wr_way", o_way, m_q[0].way);
        check("wr_tag", o_tag, exp_tag(m_q[0].tag));
      end
    end
    @(posedge clock);
    if (in_init || wr || m_q.size() == 0) m_starve = 0;
    else if (m_starve < STARVE_MAX) m_starve++;
    if (wr) void'(m_q.pop_front());
    if (iv) begin
      e.way = way; e.set = addr[12:6]; e.tag = addr[35:12];
      if (m_q.size() < DEPTH) m_q.push_back(e);
      else m_ovf = 1'b1;
    end
    if (m_cycle < NSETS) m_cycle++;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(0, 8'h00, 36'h0, 0, 7'd0);
  endtask

  task automatic rand_cycles(input int n);
    logic [35:0] a;
    for (int k = 0; k < n; k++) begin
      a = {$urandom, $urandom};
      a[12:6] = 7'($urandom_range(0, 7));
      do_cycle($urandom_range(0, 99) < 45, 8'(1 << $urandom_range(0, 7)), a,
               $urandom_range(0, 99) < 60, 7'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wen, n_grant;
    bit seen;
    reset = 1'b0;
    io_in_valid = 1'b0; io_in_bits_way_en = '0; io_in_bits_addr = '0;
    io_rd_valid = 1'b0; io_rd_set = '0;
    model_reset();
    @(negedge clock);
    apply_reset();

    // Zero sweep: 128 writes, a read nacked, one request buffered during INIT.
    n_wen = 0;
    for (int k = 0; k < NSETS; k++) begin
      do_cycle(k == 100, 8'h02, 36'h0_0000_0A40, k == 3, 7'd1);
      if (k == 3) check("init_read_nack", o_nack, 1);
      if (o_wen) n_wen++;
    end
    check("init_wen_cycles", n_wen, NSETS);
    do_cycle(0, 8'h00, 36'h0, 0, 7'd0);
    check("init_done_rise", io_init_done, 1);
    check("init_buffered_set", o_set, 7'h29);
    idle(2);

    // Single write, visible the cycle after enqueue.
    do_cycle(1, 8'h04, 36'h0_1234_5678, 0, 7'd0);
    check("first_no_bypass", o_wen, 0);
    do_cycle(0, 8'h00, 36'h0, 0, 7'd0);
    check("first_wen", o_wen, 1);
    check("first_set", o_set, 7'h59);
    check("first_way", o_way, 8'h04);
    check("first_tag", o_tag[23:0], 24'h012345);
    idle(1);

    // Read colliding with a pending write to set 5 is nacked; the write goes.
    do_cycle(1, 8'h01, 36'h0_ABCD_0140, 0, 7'd0);
    do_cycle(0, 8'h00, 36'h0, 1, 7'd5);
    check("conf_nack", o_nack, 1);
    check("conf_wen", o_wen, 1);
    do_cycle(0, 8'h00, 36'h0, 1, 7'd5);
    check("conf_regrant", o_ren, 1);

    // Starvation bound: 8 reads granted, then a forced write.
    do_cycle(1, 8'h08, 36'h0_0000_00C0, 1, 7'd9);
    n_grant = 0; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      do_cycle(0, 8'h00, 36'h0, 1, 7'd9);
      if (o_wen) begin
        seen = 1;
        check("starve_forced_nack", o_nack, 1);
        check("starve_forced_set", o_set, 7'd3);
      end else if (o_ren) n_grant++;
    end
    check("starve_grants", n_grant, 8);
    check("starve_forced_seen", seen, 1);
    idle(1);

    // Five writes while reads hold the port: fifth dropped, four drain in order.
    for (int k = 0; k < 5; k++)
      do_cycle(1, 8'h10, (36'(k + 1) << 13) | (36'(20 + k) << 6), 1, 7'd9);
    for (int k = 0; k < 4; k++) begin
      do_cycle(0, 8'h00, 36'h0, 0, 7'd0);
      check("ovf_sticky", o_ovf, 1);
      check("drain_wen", o_wen, 1);
      check("drain_set", o_set, 7'(20 + k));
    end
    do_cycle(0, 8'h00, 36'h0, 0, 7'd0);
    check("drain_done", o_wen, 0);
    check("ovf_still", o_ovf, 1);

    // Tag 7 (odd number of ones): parity bit set when parity is built in.
    do_cycle(1, 8'h20, 36'h0_0000_7000, 0, 7'd0);
    do_cycle(0, 8'h00, 36'h0, 0, 7'd0);
    check("tag7", o_tag, exp_tag(24'h000007));

    // Random traffic, reset mid-drain, reset mid-sweep, more random traffic.
    rand_cycles(150);
    apply_reset();
    rand_cycles(40);
    apply_reset();
    rand_cycles(NSETS + 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
